// File: rtl/tdm_demux_1x4_pkg.sv
// Shared types and helpers for the 1-to-4 TDM demultiplexer.
package tdm_demux_1x4_pkg;

    localparam int NUM_LANES = 4;
    localparam int SLOT_W    = 2;

    // Framing state: HUNT waits for a frame_sync word, LOCKED tracks slots.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [SLOT_W-1:0] lane_idx_t;

    // One-hot lane mask for a lane index.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
        logic [NUM_LANES-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/tdm_demux_1x4_slot_tracker.sv
// Framing state machine and slot counter: decides which lane (if any)
// receives the current word and raises the framing status pulses.
module tdm_demux_1x4_slot_tracker
    import tdm_demux_1x4_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      din_valid_i,
    input  logic      frame_sync_i,
    input  logic      mode_auto_i,
    input  lane_idx_t sel_i,
    output lane_idx_t lane_idx_o,
    output logic      wr_en_o,
    output logic      frame_done_o,
    output logic      sync_err_o,
    output logic      locked_o
);

    state_e    state_q, state_d;
    lane_idx_t slot_q, slot_d;
    logic      mode_q;
    logic      frame_done_q, frame_done_d;
    logic      sync_err_q, sync_err_d;

    // Effective state/slot after a manual-to-auto switch has been applied.
    state_e    eff_state;
    lane_idx_t eff_slot;

    // Next-state, write decision and status pulses for the current word.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d      = state_q;
        slot_d       = slot_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        wr_en_o      = 1'b0;
        lane_idx_o   = slot_q;
        eff_state    = state_q;
        eff_slot     = slot_q;

        if (!mode_auto_i) begin
            // Manual: sel routes every valid word, framing is held idle.
            state_d    = HUNT;
            slot_d     = '0;
            wr_en_o    = din_valid_i;
            lane_idx_o = sel_i;
        end else begin
            // A fresh entry into auto mode starts hunting on this very word.
            if (!mode_q) begin
                eff_state = HUNT;
                eff_slot  = '0;
            end
            state_d = eff_state;
            slot_d  = eff_slot;

            if (din_valid_i) begin
                unique case (eff_state)
                    HUNT: begin
                        if (frame_sync_i) begin
                            wr_en_o    = 1'b1;
                            lane_idx_o = '0;
                            slot_d     = lane_idx_t'(1);
                            state_d    = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (frame_sync_i) begin
                            // Sync on slot 0 is normal; anywhere else it
                            // flags an early sync and restarts the frame.
                            wr_en_o    = 1'b1;
                            lane_idx_o = '0;
                            slot_d     = lane_idx_t'(1);
                            sync_err_d = (eff_slot != '0);
                        end else if (eff_slot == '0) begin
                            // Expected sync is missing: drop word, re-hunt.
                            sync_err_d = 1'b1;
                            state_d    = HUNT;
                            slot_d     = '0;
                        end else begin
                            wr_en_o      = 1'b1;
                            lane_idx_o   = eff_slot;
                            slot_d       = eff_slot + lane_idx_t'(1);
                            frame_done_d = (eff_slot == lane_idx_t'(NUM_LANES - 1));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, slot counter, mode history and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            mode_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            slot_q       <= slot_d;
            mode_q       <= mode_auto_i;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;
    assign locked_o     = (state_q == LOCKED);

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1-to-4 TDM demultiplexer: routes a time-multiplexed word stream onto
// four registered output lanes, by sel (manual) or by frame slot (auto).
module tdm_demux_1x4
    import tdm_demux_1x4_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    input  logic                 mode_auto,
    input  logic [1:0]           sel,
    output logic [NUM_LANES*W-1:0] dout,
    output logic [NUM_LANES-1:0] dout_valid,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 locked
);

    lane_idx_t lane_idx;
    logic      wr_en;

    // Packed so that lane k lands on dout[k*W +: W].
    logic [NUM_LANES-1:0][W-1:0] lanes_q;
    logic [NUM_LANES-1:0]        dout_valid_q;

    tdm_demux_1x4_slot_tracker u_slot_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid_i  (din_valid),
        .frame_sync_i (frame_sync),
        .mode_auto_i  (mode_auto),
        .sel_i        (sel),
        .lane_idx_o   (lane_idx),
        .wr_en_o      (wr_en),
        .frame_done_o (frame_done),
        .sync_err_o   (sync_err),
        .locked_o     (locked)
    );

    // Lane registers hold their word until rewritten; valid strobes pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the lane storage is reset because dout must read 0
            // after reset; it is only four words, not a RAM.
            lanes_q      <= '0;
            dout_valid_q <= '0;
        end else begin
            dout_valid_q <= wr_en ? lane_onehot(lane_idx) : '0;
            if (wr_en) begin
                lanes_q[lane_idx] <= din;
            end
        end
    end

    assign dout       = lanes_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Self-checking bench for tdm_demux_1x4: vector table through a scoreboard
// queue, plus an asynchronous mid-run reset sequence.
module tb_tdm_demux_1x4;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          frame_sync;
    logic          mode_auto;
    logic [1:0]    sel;
    logic [4*W-1:0] dout;
    logic [3:0]    dout_valid;
    logic          frame_done;
    logic          sync_err;
    logic          locked;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        m;
        logic        v;
        logic        fs;
        logic [1:0]  sel;
        logic [7:0]  din;
        logic [31:0] e_dout;
        logic [3:0]  e_dv;
        logic        e_fd;
        logic        e_se;
        logic        e_lk;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    tdm_demux_1x4 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .mode_auto  (mode_auto),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic v, input logic fs, input logic [1:0] s,
                       input logic [7:0] d, input logic [31:0] e_dout, input logic [3:0] e_dv,
                       input logic e_fd, input logic e_se, input logic e_lk);
        vec_t t;
        t.m = m; t.v = v; t.fs = fs; t.sel = s; t.din = d;
        t.e_dout = e_dout; t.e_dv = e_dv; t.e_fd = e_fd; t.e_se = e_se; t.e_lk = e_lk;
        vecs.push_back(t);
    endtask

    // Drive one cycle of stimulus just after a falling edge, expect the
    // result on the next falling edge (after the rising edge in between).
    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        mode_auto  = t.m;
        din_valid  = t.v;
        frame_sync = t.fs;
        sel        = t.sel;
        din        = t.din;
        sb.push_back(t);
        @(negedge clk);
        if (sb.size() == 0) begin
            check($sformatf("v%0d_scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_dout", idx),       dout,              e.e_dout);
            check($sformatf("v%0d_dout_valid", idx), {28'd0, dout_valid}, {28'd0, e.e_dv});
            check($sformatf("v%0d_frame_done", idx), {31'd0, frame_done}, {31'd0, e.e_fd});
            check($sformatf("v%0d_sync_err", idx),   {31'd0, sync_err},   {31'd0, e.e_se});
            check($sformatf("v%0d_locked", idx),     {31'd0, locked},     {31'd0, e.e_lk});
        end
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        mode_auto = 1'b0; sel = 2'd0;

        // dout shown as {lane3, lane2, lane1, lane0}
        //   m  v  fs sel din      dout           dv       fd se lk
        add(1, 0, 0, 0, 8'h00, 32'h00000000, 4'b0000, 0, 0, 0); // idle after reset
        add(1, 0, 0, 0, 8'h00, 32'h00000000, 4'b0000, 0, 0, 0);
        add(0, 1, 0, 2, 8'hA5, 32'h00A50000, 4'b0100, 0, 0, 0); // manual routing
        add(0, 1, 0, 1, 8'hA5, 32'h00A5A500, 4'b0010, 0, 0, 0);
        add(0, 1, 0, 0, 8'hA5, 32'h00A5A5A5, 4'b0001, 0, 0, 0);
        add(0, 1, 0, 3, 8'hA5, 32'hA5A5A5A5, 4'b1000, 0, 0, 0);
        add(0, 1, 1, 0, 8'h3C, 32'hA5A5A53C, 4'b0001, 0, 0, 0); // sync ignored
        add(0, 0, 0, 0, 8'h00, 32'hA5A5A53C, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 8'h11, 32'hA5A5A511, 4'b0001, 0, 0, 1); // auto frame
        add(1, 1, 0, 0, 8'h22, 32'hA5A52211, 4'b0010, 0, 0, 1);
        add(1, 0, 0, 0, 8'h00, 32'hA5A52211, 4'b0000, 0, 0, 1); // gap holds slot
        add(1, 1, 0, 0, 8'h33, 32'hA5332211, 4'b0100, 0, 0, 1);
        add(1, 1, 0, 0, 8'h44, 32'h44332211, 4'b1000, 1, 0, 1);
        add(1, 1, 1, 0, 8'h11, 32'h44332211, 4'b0001, 0, 0, 1); // early sync
        add(1, 1, 0, 0, 8'h22, 32'h44332211, 4'b0010, 0, 0, 1);
        add(1, 1, 1, 0, 8'h55, 32'h44332255, 4'b0001, 0, 1, 1);
        add(1, 1, 0, 0, 8'h77, 32'h44337755, 4'b0010, 0, 0, 1);
        add(1, 1, 0, 0, 8'h88, 32'h44887755, 4'b0100, 0, 0, 1);
        add(1, 1, 0, 0, 8'h99, 32'h99887755, 4'b1000, 1, 0, 1);
        add(1, 1, 0, 0, 8'h66, 32'h99887755, 4'b0000, 0, 1, 0); // missing sync
        add(1, 1, 0, 0, 8'hAA, 32'h99887755, 4'b0000, 0, 0, 0); // discarded in HUNT
        add(1, 1, 1, 0, 8'hBB, 32'h998877BB, 4'b0001, 0, 0, 1);
        add(1, 1, 0, 0, 8'hCC, 32'h9988CCBB, 4'b0010, 0, 0, 1);
        add(0, 0, 0, 0, 8'h00, 32'h9988CCBB, 4'b0000, 0, 0, 0); // manual mid-frame
        add(1, 1, 1, 0, 8'hDD, 32'h9988CCDD, 4'b0001, 0, 0, 1); // 0->1 with sync
        add(1, 1, 0, 0, 8'hEE, 32'h9988EEDD, 4'b0010, 0, 0, 1);
        add(0, 0, 0, 0, 8'h00, 32'h9988EEDD, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 0, 8'hF0, 32'h9988EEDD, 4'b0000, 0, 0, 0); // 0->1 no sync

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Build up a partial frame, then reset asynchronously mid-cycle.
        mode_auto = 1'b1; din_valid = 1'b1; frame_sync = 1'b1; din = 8'h5A;
        @(negedge clk);
        frame_sync = 1'b0; din = 8'h6B;
        @(negedge clk);
        check("pre_reset_locked", {31'd0, locked}, 32'd1);
        check("pre_reset_dout", dout, 32'h99886B5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", dout, 32'h0);
        check("async_rst_dout_valid", {28'd0, dout_valid}, 32'h0);
        check("async_rst_frame_done", {31'd0, frame_done}, 32'h0);
        check("async_rst_sync_err", {31'd0, sync_err}, 32'h0);
        check("async_rst_locked", {31'd0, locked}, 32'h0);
        din_valid = 1'b0; frame_sync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            vec_t t;
            t = '{m:1, v:0, fs:0, sel:0, din:8'h00, e_dout:32'h0, e_dv:4'b0000, e_fd:0, e_se:0, e_lk:0};
            apply(t, 100);
            t = '{m:1, v:1, fs:0, sel:0, din:8'h12, e_dout:32'h0, e_dv:4'b0000, e_fd:0, e_se:0, e_lk:0};
            apply(t, 101);
            t = '{m:1, v:1, fs:1, sel:0, din:8'h34, e_dout:32'h00000034, e_dv:4'b0001, e_fd:0, e_se:0, e_lk:1};
            apply(t, 102);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receiving end of the 4-to-1 multiplexer datapath: takes one W-bit time-multiplexed stream and routes each word to one of four registered output lanes.
- Two modes, chosen by mode_auto:
  - Manual: the lane is chosen by the sel input.
  - Auto: the lane is chosen by an internal slot counter that is aligned by a frame_sync marker.
- Sits at the far end of a shared serial or narrow link, restoring the four parallel channels.

Parameters:
- W, 8: data width of each lane and of the input stream.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- din, input, W: multiplexed input word.
- din_valid, input, 1: din carries a word this cycle.
- frame_sync, input, 1: qualified by din_valid; marks the current word as slot 0.
- mode_auto, input, 1: 1 = internal slot counter selects the lane; 0 = sel selects the lane.
- sel, input, 2: lane select in manual mode; ignored in auto mode.
- dout, output, 4*W: lane k occupies bits [k*W +: W]; each lane holds its value until rewritten.
- dout_valid, output, 4: one-cycle pulse per lane when that lane is written.
- frame_done, output, 1: one-cycle pulse when lane 3 is written in LOCKED.
- sync_err, output, 1: one-cycle pulse on a framing violation.
- locked, output, 1: 1 while the state machine is in LOCKED.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - dout=0, dout_valid=0, frame_done=0, sync_err=0, locked=0.
  - Slot counter = 0, state = HUNT, registered copy of mode_auto = 0.
- All outputs are registered. Latency: a word accepted on edge N appears on dout, with its dout_valid bit, after edge N.
- Manual mode (mode_auto=0):
  - Every cycle with din_valid=1: lane[sel] <= din and dout_valid[sel] pulses.
  - frame_sync is ignored; frame_done and sync_err stay 0.
  - State is forced to HUNT, the slot counter held at 0, and locked=0.
- Auto mode, state machine (2 states):
  - HUNT, din_valid & frame_sync: write lane0, slot <= 1, go to LOCKED.
  - HUNT, din_valid & !frame_sync: discard the word, no pulses.
  - LOCKED, din_valid & !frame_sync with slot != 0: write lane[slot], slot <= slot+1 (3 wraps to 0). frame_done pulses when slot == 3.
  - LOCKED, din_valid & frame_sync with slot == 0: normal write of lane0, slot <= 1.
  - LOCKED, din_valid & frame_sync with slot != 0 (early sync): sync_err pulses; resynchronise by writing lane0, slot <= 1, staying in LOCKED. The partial frame gets no frame_done.
  - LOCKED, din_valid & !frame_sync with slot == 0 (missing sync): sync_err pulses, the word is discarded, go to HUNT, slot <= 0.
  - din_valid=0: no state change, no writes, no pulses.
- Mode switch:
  - A 0->1 transition of mode_auto (compared against the registered copy) forces HUNT and slot 0 on that edge.
  - A word presented on that same cycle is evaluated under HUNT rules.
- Reset mid-frame: immediate return to the reset values above; the partial frame is lost.
- Width rules:
  - The slot counter is 2 bits and wraps naturally.
  - No arithmetic is performed on data; din is copied into the lane unchanged.

Decomposition:
- Shared package: state enum (HUNT, LOCKED), NUM_LANES=4, SLOT_W=2, and a lane-index helper function.
- One natural sub-module: tdm_slot_tracker, containing the state machine, slot counter, sync_err, frame_done and locked. It outputs the current lane index and a write enable. The top level holds the lane registers and the dout_valid decode.

Test Plan:
- Reset check: with rst_n=0 mid-run -> all outputs 0 asynchronously (without waiting for a clock edge) and locked=0. After release with mode_auto=1 and din_valid=0 -> still 0.
- Manual routing: mode_auto=0, din=8'hA5, sel=2,1,0,3 on consecutive valid cycles (in=0111 style pattern) -> lane2=A5, lane1=A5, lane0=A5, lane3=A5. dout_valid shows one-hot 0100, 0010, 0001, 1000 one cycle after each.
- Auto frame: mode_auto=1, words 11,22,33,44 with frame_sync on 11 -> lanes 0..3 = 11,22,33,44; frame_done pulses once with dout_valid=1000; locked=1 from the cycle after 11.
- Early sync: in LOCKED after words 11,22, send 55 with frame_sync -> sync_err=1 for one cycle, lane0=55, next word goes to lane1, no frame_done for the broken frame.
- Missing sync: after a full frame, send 66 without frame_sync -> sync_err=1, lane0 unchanged, locked=0. Next words without sync are discarded until a sync word arrives.
- Gaps and mode switch: din_valid low between words -> slot holds. Toggle mode_auto 0->1 in the middle of a frame -> HUNT; a word with frame_sync on that same cycle lands in lane0.
